// File: rtl/sm_hex_scan_ctrl.sv
// rtl/sm_hex_scan_ctrl.sv - time-multiplexed seven-segment digit scanner with frame-synchronous commit
module sm_hex_scan_ctrl #(
  parameter int DIGITS       = 3,
  parameter int DWELL        = 50000,
  parameter int BLANK        = 1000,
  parameter int SEG_ACT_HIGH = 1,
  parameter int DIG_ACT_HIGH = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   en_in,
  output logic [6:0]          seg_out,
  output logic                dp_out,
  output logic [DIGITS-1:0]   dig_out,
  output logic                pending,
  output logic                frame_done
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Inactive ("dark") levels; lit patterns are the active-high form XORed with these.
  localparam logic [6:0]        SEG_OFF = (SEG_ACT_HIGH != 0) ? 7'h00 : 7'h7f;
  localparam logic              DP_OFF  = (SEG_ACT_HIGH == 0);
  localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACT_HIGH != 0) ? {DIGITS{1'b0}} : {DIGITS{1'b1}};

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic                pend_q, pend_d;
  logic                fd_q, fd_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic [3:0]          nib;
  logic                nib_dp, nib_en;

  // Active-high gfedcba hex font.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3f;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5b;  4'h3: hex7 = 7'h4f;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6d;  4'h6: hex7 = 7'h7d;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7f;  4'h9: hex7 = 7'h6f;  4'ha: hex7 = 7'h77;  4'hb: hex7 = 7'h7c;
      4'hc: hex7 = 7'h39;  4'hd: hex7 = 7'h5e;  4'he: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Scan sequencing, frame-boundary commit, shadow capture and next output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    sh_en_d    = sh_en_q;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    act_en_d   = act_en_q;
    pend_d     = pend_q;
    seg_d      = seg_q;
    dp_d       = dp_q;
    dig_d      = dig_q;
    fd_d       = 1'b0;
    nib        = 4'h0;
    nib_dp     = 1'b0;
    nib_en     = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CW'(BLANK - 1)) begin
          cnt_d   = '0;
          state_d = ST_SHOW;
          if (idx_q == IW'(DIGITS - 1)) begin
            idx_d = '0;
            fd_d  = 1'b1;
            if (pend_q) begin
              act_data_d = sh_data_q;
              act_dp_d   = sh_dp_q;
              act_en_d   = sh_en_q;
              pend_d     = 1'b0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
          // Select from the post-commit copy so digit 0 of a new frame is never stale.
          for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx_d) begin
              nib    = act_data_d[4*i +: 4];
              nib_dp = act_dp_d[i];
              nib_en = act_en_d[i];
            end
          end
          if (nib_en) begin
            seg_d = hex7(nib) ^ SEG_OFF;
            dp_d  = nib_dp ^ DP_OFF;
            dig_d = (DIGITS'(1) << idx_d) ^ DIG_OFF;
          end else begin
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
            dig_d = DIG_OFF;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d   = '0;
          state_d = ST_BLANK;
          seg_d   = SEG_OFF;
          dp_d    = DP_OFF;
          dig_d   = DIG_OFF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase
    // A load on the commit edge lands after the commit, so it stays pending for the next frame.
    if (load) begin
      sh_data_d = data_in;
      sh_dp_d   = dp_in;
      sh_en_d   = en_in;
      pend_d    = 1'b1;
    end
  end

  // State and output registers with synchronous reset to an all-dark, all-disabled display.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= IW'(DIGITS - 1);
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_en_q    <= '0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
      pend_q     <= 1'b0;
      fd_q       <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      dig_q      <= DIG_OFF;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_en_q    <= sh_en_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      act_en_q   <= act_en_d;
      pend_q     <= pend_d;
      fd_q       <= fd_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_q      <= dig_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_out    = dig_q;
  assign pending    = pend_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sm_hex_scan_ctrl.sv
// tb/tb_sm_hex_scan_ctrl.sv - directed self-checking bench for sm_hex_scan_ctrl
module tb_sm_hex_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [11:0] data_in;
  logic [2:0]  dp_in;
  logic [2:0]  en_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [2:0]  dig_out;
  logic        pending;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int frame_no = 0;

  sm_hex_scan_ctrl #(
    .DIGITS(3), .DWELL(4), .BLANK(2), .SEG_ACT_HIGH(1), .DIG_ACT_HIGH(0)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in), .en_in(en_in),
    .seg_out(seg_out), .dp_out(dp_out), .dig_out(dig_out), .pending(pending),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one 18-cycle frame starting at the boundary edge; optional loads at cycle offsets la/lb.
  task automatic check_frame(
    input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
    input logic [2:0] en, input logic [2:0] dp, input logic pend0,
    input int la, input logic [11:0] da, input logic [2:0] ea, input logic [2:0] pa,
    input int lb, input logic [11:0] db, input logic [2:0] eb, input logic [2:0] pb);
    logic [6:0] segs [3];
    logic [6:0] e_seg;
    logic [2:0] e_dig;
    logic       e_dp, exp_pend, lit;
    int         slot, pos;
    segs[0] = s0; segs[1] = s1; segs[2] = s2;
    exp_pend = pend0;
    frame_no++;
    for (int c = 0; c < 18; c++) begin
      tick();
      load = 1'b0;
      if ((la >= 0 && c == la + 1) || (lb >= 0 && c == lb + 1)) exp_pend = 1'b1;
      slot = c / 6;
      pos  = c % 6;
      lit  = (pos < 4) && en[slot];
      e_dig = lit ? ~(3'b001 << slot) : 3'b111;
      e_seg = lit ? segs[slot] : 7'h00;
      e_dp  = lit ? dp[slot] : 1'b0;
      chk($sformatf("f%0d c%0d dig", frame_no, c), {29'b0, dig_out}, {29'b0, e_dig});
      chk($sformatf("f%0d c%0d seg", frame_no, c), {25'b0, seg_out}, {25'b0, e_seg});
      chk($sformatf("f%0d c%0d dp", frame_no, c), {31'b0, dp_out}, {31'b0, e_dp});
      chk($sformatf("f%0d c%0d frame_done", frame_no, c), {31'b0, frame_done}, (c == 0) ? 32'd1 : 32'd0);
      chk($sformatf("f%0d c%0d pending", frame_no, c), {31'b0, pending}, {31'b0, exp_pend});
      if (c == la) begin data_in = da; en_in = ea; dp_in = pa; load = 1'b1; end
      if (c == lb) begin data_in = db; en_in = eb; dp_in = pb; load = 1'b1; end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; en_in = '0;
    repeat (3) tick();
    chk("rst dig", {29'b0, dig_out}, 32'h7);
    chk("rst seg", {25'b0, seg_out}, 32'h0);
    chk("rst dp", {31'b0, dp_out}, 32'h0);
    chk("rst pending", {31'b0, pending}, 32'h0);
    chk("rst frame_done", {31'b0, frame_done}, 32'h0);
    rst = 1'b0;
    tick();
    chk("edge1 frame_done", {31'b0, frame_done}, 32'h0);
    chk("edge1 dig", {29'b0, dig_out}, 32'h7);

    // Disabled display, then a mid-frame load that must wait for the boundary.
    check_frame(7'h00, 7'h00, 7'h00, 3'b000, 3'b000, 1'b0,
                -1, 12'h0, 3'b0, 3'b0, -1, 12'h0, 3'b0, 3'b0);
    check_frame(7'h00, 7'h00, 7'h00, 3'b000, 3'b000, 1'b0,
                5, 12'h3A5, 3'b111, 3'b010, -1, 12'h0, 3'b0, 3'b0);
    // 3A5 shown; two loads in the frame, latest wins.
    check_frame(7'h6d, 7'h77, 7'h4f, 3'b111, 3'b010, 1'b0,
                3, 12'h111, 3'b111, 3'b000, 10, 12'h222, 3'b111, 3'b000);
    // 222 shown; load mid-frame, then another on the commit edge itself.
    check_frame(7'h5b, 7'h5b, 7'h5b, 3'b111, 3'b000, 1'b0,
                8, 12'h456, 3'b111, 3'b001, 17, 12'h0F8, 3'b111, 3'b100);
    check_frame(7'h7d, 7'h6d, 7'h66, 3'b111, 3'b001, 1'b1,
                -1, 12'h0, 3'b0, 3'b0, -1, 12'h0, 3'b0, 3'b0);
    check_frame(7'h7f, 7'h71, 7'h3f, 3'b111, 3'b100, 1'b0,
                4, 12'h7C9, 3'b101, 3'b000, -1, 12'h0, 3'b0, 3'b0);
    // Digit 1 disabled: its slot stays dark, others keep their timing.
    check_frame(7'h6f, 7'h00, 7'h07, 3'b101, 3'b000, 1'b0,
                7, 12'hABC, 3'b111, 3'b111, -1, 12'h0, 3'b0, 3'b0);
    check_frame(7'h39, 7'h7c, 7'h77, 3'b111, 3'b111, 1'b0,
                2, 12'h000, 3'b111, 3'b000, -1, 12'h0, 3'b0, 3'b0);

    // Reset in the middle of digit 1 with data pending.
    tick();
    chk("f9 frame_done", {31'b0, frame_done}, 32'h1);
    repeat (3) tick();
    data_in = 12'h999; en_in = 3'b111; dp_in = 3'b000; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (3) tick();
    chk("f9 mid pending", {31'b0, pending}, 32'h1);
    chk("f9 mid dig", {29'b0, dig_out}, 32'h5);
    chk("f9 mid seg", {25'b0, seg_out}, 32'h3f);
    rst = 1'b1;
    tick();
    chk("midrst dig", {29'b0, dig_out}, 32'h7);
    chk("midrst seg", {25'b0, seg_out}, 32'h0);
    chk("midrst dp", {31'b0, dp_out}, 32'h0);
    chk("midrst pending", {31'b0, pending}, 32'h0);
    chk("midrst frame_done", {31'b0, frame_done}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk($sformatf("post k%0d dig", k), {29'b0, dig_out}, 32'h7);
      chk($sformatf("post k%0d seg", k), {25'b0, seg_out}, 32'h0);
      chk($sformatf("post k%0d pending", k), {31'b0, pending}, 32'h0);
      chk($sformatf("post k%0d frame_done", k), {31'b0, frame_done},
          (k == 1 || k == 19 || k == 37) ? 32'd1 : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sm_hex_scan_ctrl.md
# sm_hex_scan_ctrl

Time-multiplexing scheduler for the board's shared seven-segment segment lines. It sequences the on-board digits one at a time, inserting a dark gap between digits so no segment pattern ghosts onto the next digit. New display data is accepted at any time through a load strobe and applied only at a frame boundary, so a frame never shows mixed old and new values. It sits between the core's debug register readout and the board GPIO segment and digit pins, and replaces free-running blink logic.

## Interface
- DIGITS, 3: number of multiplexed digits, 1..8.
- DWELL, 50000: clock cycles each digit is lit, ≥1.
- BLANK, 1000: clock cycles all digits are dark between digits, ≥1.
- SEG_ACT_HIGH, 1: segment/dp polarity. 1 means lit = 1.
- DIG_ACT_HIGH, 0: digit-select polarity. 0 means selected = 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures data_in, dp_in and en_in into the shadow register.
- data_in  in  4*DIGITS  hex nibbles; nibble i drives digit i.
- dp_in  in  DIGITS  decimal point per digit.
- en_in  in  DIGITS  digit enable; 0 means the digit's slot stays dark.
- seg_out  out  7  segments, bit0 = a … bit6 = g.
- dp_out  out  1  decimal point of the current digit.
- dig_out  out  DIGITS  one-hot digit select at the active level.
- pending  out  1  the shadow holds data not yet committed.
- frame_done  out  1  one-cycle pulse on each frame boundary.

## Operation
- Registers:
  - idx: digit index, 0..DIGITS-1.
  - state: BLANK or SHOW.
  - cnt: dwell/blank counter.
  - shadow and active copies of data, dp and en.
  - pending, plus the registered outputs.
- Reset values:
  - idx = DIGITS-1, state = BLANK, cnt = 0.
  - shadow and active cleared, so all digits are disabled.
  - pending = 0, frame_done = 0.
  - seg_out, dp_out and dig_out inactive, i.e. all dark.
- FSM:
  - BLANK: all outputs inactive. When cnt = BLANK-1: set cnt = 0, idx = (idx+1) mod DIGITS, go to SHOW.
  - SHOW: when cnt = DWELL-1: set cnt = 0, go to BLANK. Otherwise cnt increments.
- Frame boundary: the BLANK→SHOW transition where idx wraps from DIGITS-1 to 0. On that edge:
  - frame_done = 1 for that one cycle.
  - If pending, the shadow is copied to active and pending clears.
  - The digit-0 outputs use the newly committed values.
- SHOW output, for digit idx:
  - dig_out[idx] is active and all other bits are inactive.
  - seg_out is the hex decode of active nibble idx.
  - dp_out = active dp[idx].
  - If active en[idx] = 0, seg_out, dp_out and dig_out all stay inactive. The slot time is still consumed, which keeps per-digit brightness constant.
- Hex decode (active-high, gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. The pattern is inverted when SEG_ACT_HIGH = 0.
- load:
  - The shadow captures the inputs and pending is set.
  - Repeated loads before a commit overwrite the shadow; the latest one wins.
  - A load in the commit cycle: the old shadow is committed, the new value is captured, and pending stays 1. It commits at the next boundary.
- rst mid-frame: the next edge restores all reset values. Any pending data is discarded.

## Timing
- All outputs are registered and change only on the state-transition edge.
- After each SHOW entry edge, a selected digit is active for exactly DWELL consecutive cycles.
- Between any two lit slots, all digits are dark for exactly BLANK cycles. Two digits are never active in the same cycle.
- Frame length is DIGITS × (DWELL + BLANK) cycles.
- After rst is released, the first frame_done and the digit-0 SHOW occur on the BLANK-th edge.
- load-to-visible latency is at most one frame + BLANK cycles. pending rises on the edge after load.

## Test plan
Setup: DIGITS=3, DWELL=4, BLANK=2, SEG_ACT_HIGH=1, DIG_ACT_HIGH=0.

1. Reset release with no load -> frame_done pulses every 18 cycles. dig_out stays 3'b111 and seg_out stays 0 throughout, since all digits are disabled.
2. load with data_in=12'h3A5, en_in=3'b111, dp_in=3'b010 -> pending=1 until the next boundary, then clears. The frame shows:
   - 4 cycles of dig_out=110, seg=6D, dp=0;
   - 2 cycles dark;
   - 4 cycles of dig_out=101, seg=77, dp=1;
   - 2 cycles dark;
   - 4 cycles of dig_out=011, seg=4F.
3. Two loads (12'h111, then 12'h222) in the same frame -> only 222 is ever displayed. No frame shows 1.
4. load on the exact frame_done cycle -> the frame starting then shows the previously loaded value, pending stays 1, and the new value appears one frame later.
5. en_in=3'b101 -> the digit-1 slot stays fully dark for 4 cycles, and the slot timing of digits 0 and 2 is unchanged.
6. rst asserted mid-SHOW of digit 1 while pending=1 -> the next cycle is all dark with pending=0, and the display stays dark after release.
